// File: rtl/apb_arbiter_2to1.sv
// apb_arbiter_2to1: round-robin 2:1 APB arbiter, grant held for a whole
// transfer, optional PREADY timeout that force-completes a hung access.
module apb_arbiter_2to1 #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                TIMEOUT  = 0,
    parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S0_PSEL,
    input  logic              S0_PENABLE,
    input  logic              S0_PWRITE,
    input  logic [ADDR_W-1:0] S0_PADDR,
    input  logic [DATA_W-1:0] S0_PWDATA,
    output logic [DATA_W-1:0] S0_PRDATA,
    output logic              S0_PREADY,
    input  logic              S1_PSEL,
    input  logic              S1_PENABLE,
    input  logic              S1_PWRITE,
    input  logic [ADDR_W-1:0] S1_PADDR,
    input  logic [DATA_W-1:0] S1_PWDATA,
    output logic [DATA_W-1:0] S1_PRDATA,
    output logic              S1_PREADY,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [1:0]        GRANT,
    output logic              TIMEOUT_PULSE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_ptr, w_ptr_nx;
    logic [1:0]        r_grant, w_grant_nx;
    logic              r_psel, w_psel_nx;
    logic              r_penable, w_penable_nx;
    logic              r_pwrite, w_pwrite_nx;
    logic [ADDR_W-1:0] r_paddr, w_paddr_nx;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_nx;

    logic              w_pick1;
    logic              w_expire;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    // Either APB phase counts as a request; the enables carry no extra info
    assign w_unused = &{1'b0, S0_PENABLE, S1_PENABLE};

    // r_ptr=1 means S1 wins a tie
    assign w_pick1 = S1_PSEL && (!S0_PSEL || r_ptr);
    assign w_done  = (r_state == ST_ACCESS) && (PREADY || w_expire);
    assign w_rdata = PREADY ? PRDATA : ERR_DATA;

    generate
        if (TIMEOUT > 0) begin : g_to
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] r_cnt;

            assign w_expire = (r_state == ST_ACCESS) && !PREADY &&
                              (r_cnt == CNT_W'(TIMEOUT));

            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    r_cnt <= '0;
                else if (r_state != ST_ACCESS)
                    r_cnt <= '0;
                else if (!PREADY && !w_expire)
                    r_cnt <= r_cnt + 1'b1;
            end
        end else begin : g_no_to
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 1'b0;
            r_grant   <= 2'b00;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_grant   <= w_grant_nx;
            r_psel    <= w_psel_nx;
            r_penable <= w_penable_nx;
            r_pwrite  <= w_pwrite_nx;
            r_paddr   <= w_paddr_nx;
            r_pwdata  <= w_pwdata_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_grant_nx   = r_grant;
        w_psel_nx    = r_psel;
        w_penable_nx = r_penable;
        w_pwrite_nx  = r_pwrite;
        w_paddr_nx   = r_paddr;
        w_pwdata_nx  = r_pwdata;
        unique case (r_state)
            ST_IDLE: begin
                if (S0_PSEL || S1_PSEL) begin
                    w_grant_nx   = w_pick1 ? 2'b10 : 2'b01;
                    w_pwrite_nx  = w_pick1 ? S1_PWRITE : S0_PWRITE;
                    w_paddr_nx   = w_pick1 ? S1_PADDR : S0_PADDR;
                    w_pwdata_nx  = w_pick1 ? S1_PWDATA : S0_PWDATA;
                    w_psel_nx    = 1'b1;
                    w_penable_nx = 1'b0;
                    w_state_nx   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable_nx = 1'b1;
                w_state_nx   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_done) begin
                    w_psel_nx    = 1'b0;
                    w_penable_nx = 1'b0;
                    w_grant_nx   = 2'b00;
                    w_ptr_nx     = r_grant[0];
                    w_state_nx   = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign PSEL          = r_psel;
    assign PENABLE       = r_penable;
    assign PWRITE        = r_pwrite;
    assign PADDR         = r_paddr;
    assign PWDATA        = r_pwdata;
    assign GRANT         = r_grant;
    assign TIMEOUT_PULSE = w_expire;

    assign S0_PREADY = w_done && r_grant[0];
    assign S1_PREADY = w_done && r_grant[1];
    assign S0_PRDATA = S0_PREADY ? w_rdata : '0;
    assign S1_PRDATA = S1_PREADY ? w_rdata : '0;

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// tb_apb_arbiter_2to1: two APB master drivers, a wait-state peripheral
// model and a downstream scoreboard for the 2:1 arbiter.
module tb_apb_arbiter_2to1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s0_psel = 0, s0_penable = 0, s0_pwrite = 0;
    logic [7:0] s0_paddr = 0, s0_pwdata = 0;
    logic [7:0] s0_prdata;
    logic       s0_pready;
    logic       s1_psel = 0, s1_penable = 0, s1_pwrite = 0;
    logic [7:0] s1_paddr = 0, s1_pwdata = 0;
    logic [7:0] s1_prdata;
    logic       s1_pready;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready;
    logic [1:0] gnt;
    logic       tpulse;

    int pr_wait = 0;
    bit pr_hang = 0;
    int acc_cnt;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] g;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       to;
    } item_t;
    item_t exp_q[$];

    apb_arbiter_2to1 #(
        .ADDR_W(8), .DATA_W(8), .TIMEOUT(4), .ERR_DATA(8'hFF)
    ) dut (
        .CLK(clk), .RST(rst),
        .S0_PSEL(s0_psel), .S0_PENABLE(s0_penable), .S0_PWRITE(s0_pwrite),
        .S0_PADDR(s0_paddr), .S0_PWDATA(s0_pwdata),
        .S0_PRDATA(s0_prdata), .S0_PREADY(s0_pready),
        .S1_PSEL(s1_psel), .S1_PENABLE(s1_penable), .S1_PWRITE(s1_pwrite),
        .S1_PADDR(s1_paddr), .S1_PWDATA(s1_pwdata),
        .S1_PRDATA(s1_prdata), .S1_PREADY(s1_pready),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
        .GRANT(gnt), .TIMEOUT_PULSE(tpulse)
    );

    // Peripheral: ready after pr_wait ACCESS cycles, reads return addr+0x40
    assign pready = psel && penable && !pr_hang && (acc_cnt >= pr_wait);
    assign prdata = paddr + 8'h40;

    always @(posedge clk or posedge rst) begin
        if (rst) acc_cnt <= 0;
        else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic w,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic to);
        item_t it;
        it.g = g; it.w = w; it.a = a; it.d = d; it.to = to;
        exp_q.push_back(it);
    endtask

    task automatic drv(input bit p, input logic sel, input logic en,
                       input logic wr, input logic [7:0] a,
                       input logic [7:0] d);
        if (p) begin
            s1_psel = sel; s1_penable = en; s1_pwrite = wr;
            s1_paddr = a; s1_pwdata = d;
        end else begin
            s0_psel = sel; s0_penable = en; s0_pwrite = wr;
            s0_paddr = a; s0_pwdata = d;
        end
    endtask

    // One upstream APB transfer; elat<0 skips the latency check
    task automatic xfer(input bit p, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] erd,
                        input int elat);
        int c0;
        bit got;
        logic [7:0] rd;
        drv(p, 1'b1, 1'b0, wr, a, d);
        c0 = cyc;
        @(posedge clk); #1;
        drv(p, 1'b1, 1'b1, wr, a, d);
        got = 0;
        rd = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (p ? s1_pready : s0_pready) begin
                got = 1;
                rd = p ? s1_prdata : s0_prdata;
                if (elat >= 0)
                    chk($sformatf("s%0d_lat_%0h", p, a), cyc - c0, elat);
            end
        end
        chk($sformatf("s%0d_done_%0h", p, a), got, 1);
        if (got && !wr)
            chk($sformatf("s%0d_rdata_%0h", p, a), rd, erd);
        @(posedge clk); #1;
        drv(p, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_gnt", gnt, 0);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Downstream monitor and scoreboard
    initial begin
        bit prev_setup, prev_done, done;
        logic [7:0] ca, cd;
        logic cw;
        item_t e;
        prev_setup = 0; prev_done = 0;
        ca = 0; cd = 0; cw = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_setup = 0;
                prev_done = 0;
            end else begin
                chk("s0_rdy_ungr", s0_pready && !gnt[0], 0);
                chk("s1_rdy_ungr", s1_pready && !gnt[1], 0);
                chk("rdy_src", (s0_pready || s1_pready) &&
                    !(pready || tpulse), 0);
                chk("to_prec", tpulse && pready, 0);
                if (prev_done) chk("idle_gap", psel, 0);
                if (prev_setup) chk("setup_1cyc", {psel, penable}, 2'b11);
                if (psel && !penable) begin
                    ca = paddr; cd = pwdata; cw = pwrite;
                end else if (psel && penable) begin
                    chk("stable_addr", paddr, ca);
                    chk("stable_wdata", pwdata, cd);
                    chk("stable_wr", pwrite, cw);
                end
                done = psel && penable && (pready || tpulse);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("q_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_gnt", gnt, e.g);
                        chk("sb_wr", pwrite, e.w);
                        chk("sb_addr", paddr, e.a);
                        if (e.w) chk("sb_wdata", pwdata, e.d);
                        chk("sb_tpulse", tpulse, e.to);
                        chk("sb_uprdy", {s1_pready, s0_pready}, e.g);
                    end
                end
                prev_setup = psel && !penable;
                prev_done = done;
            end
        end
    end

    initial begin
        #3;
        chk("rst0_psel", psel, 0);
        chk("rst0_pen", penable, 0);
        chk("rst0_pwr", pwrite, 0);
        chk("rst0_addr", paddr, 0);
        chk("rst0_wdata", pwdata, 0);
        chk("rst0_gnt", gnt, 0);
        chk("rst0_tp", tpulse, 0);
        #9 rst = 1'b0;

        // Single S0 write, zero-wait peripheral
        @(posedge clk); #1;
        push(2'b01, 1, 8'h12, 8'hA5, 0);
        xfer(0, 1, 8'h12, 8'hA5, 8'h00, 2);

        // Tie from fresh pointer: S0 then S1
        do_reset();
        @(posedge clk); #1;
        push(2'b01, 0, 8'h03, 8'h00, 0);
        push(2'b10, 0, 8'h04, 8'h00, 0);
        fork
            xfer(0, 0, 8'h03, 8'h00, 8'h43, 2);
            xfer(1, 0, 8'h04, 8'h00, 8'h44, 5);
        join

        // S0 back-to-back x3 against one pending S1
        @(posedge clk); #1;
        push(2'b01, 0, 8'h20, 8'h00, 0);
        push(2'b10, 0, 8'h28, 8'h00, 0);
        push(2'b01, 0, 8'h21, 8'h00, 0);
        push(2'b01, 0, 8'h22, 8'h00, 0);
        fork
            begin
                xfer(0, 0, 8'h20, 8'h00, 8'h60, 2);
                xfer(0, 0, 8'h21, 8'h00, 8'h61, -1);
                xfer(0, 0, 8'h22, 8'h00, 8'h62, 2);
            end
            xfer(1, 0, 8'h28, 8'h00, 8'h68, 5);
        join

        // Hung peripheral on S1 read: forced completion with ERR_DATA
        @(posedge clk); #1;
        pr_hang = 1;
        push(2'b10, 0, 8'h55, 8'h00, 1);
        xfer(1, 0, 8'h55, 8'h00, 8'hFF, 6);
        pr_hang = 0;
        push(2'b01, 0, 8'h10, 8'h00, 0);
        xfer(0, 0, 8'h10, 8'h00, 8'h50, 2);

        // S1 write with 3 peripheral wait states
        pr_wait = 3;
        push(2'b10, 1, 8'h7F, 8'h5A, 0);
        xfer(1, 1, 8'h7F, 8'h5A, 8'h00, 5);
        pr_wait = 0;

        // Leave pointer at S1, then reset in the middle of an S0 access
        push(2'b01, 0, 8'h30, 8'h00, 0);
        xfer(0, 0, 8'h30, 8'h00, 8'h70, 2);
        pr_hang = 1;
        drv(0, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
        @(posedge clk); #1;
        drv(0, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_acc", {psel, penable}, 2'b11);
        chk("pre_rst_gnt", gnt, 2'b01);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_psel", psel, 0);
        chk("arst_pen", penable, 0);
        chk("arst_gnt", gnt, 0);
        chk("arst_addr", paddr, 0);
        chk("arst_s0rdy", s0_pready, 0);
        chk("arst_tp", tpulse, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        pr_hang = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        push(2'b01, 0, 8'h01, 8'h00, 0);
        push(2'b10, 0, 8'h02, 8'h00, 0);
        fork
            xfer(0, 0, 8'h01, 8'h00, 8'h41, 2);
            xfer(1, 0, 8'h02, 8'h00, 8'h42, 5);
        join

        repeat (3) @(posedge clk);
        chk("q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
